// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the datapath controller and dmem_ctrl.
interface dmem_if #(
  parameter int unsigned n = 32
) ();

  logic         memwrite;
  logic         memread;
  logic [n-1:0] addr;
  logic [n-1:0] writedata;
  logic [n-1:0] readdata;
  logic         rdvalid;
  logic         stall;
  logic         misalign;

  // Controller / datapath side
  modport master (
    output memwrite, memread, addr, writedata,
    input  readdata, rdvalid, stall, misalign
  );

  // Memory controller side
  modport slave (
    input  memwrite, memread, addr, writedata,
    output readdata, rdvalid, stall, misalign
  );

endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: IDLE -> BUSY (LATENCY cycles) -> DONE.
// Optional feature macro DMEM_ALIGN_CHECK_EN: a misaligned request skips BUSY,
// performs no access and raises misalign for its DONE cycle.
module dmem_ctrl #(
  parameter int unsigned n       = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Request captured at IDLE exit; later bus changes are ignored.
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] idx;
    logic [n-1:0]  data;
  } req_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  req_t           req;
  logic [n-1:0]   mem [DEPTH];
  logic [n-1:0]   rdata;
  logic           rdvalid_q;
  logic           misalign_q;

  logic           req_c;
  logic           misaligned_c;
  logic [AW-1:0]  idx_c;
  logic           unused_addr_bits;

  // Request decode and word index (byte offset and bits above DEPTH dropped).
  assign req_c = bus.memread | bus.memwrite;
  assign idx_c = bus.addr[AW+1:2];
  assign unused_addr_bits = ^{bus.addr[n-1:AW+2], bus.addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned_c = (bus.addr[1:0] != 2'b00);
`else
  assign misaligned_c = 1'b0;
`endif

  // Stall covers the requesting IDLE cycle plus every BUSY cycle; forced low in reset.
  assign bus.stall = ~reset & (((state == IDLE) & req_c) | (state == BUSY));

  assign bus.readdata = rdata;
  assign bus.rdvalid  = rdvalid_q;
  assign bus.misalign = misalign_q;

  // Controller FSM, latency counter, memory array and registered responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req        <= '0;
      rdata      <= '0;
      rdvalid_q  <= 1'b0;
      misalign_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            // Write wins when both strobes are high.
            req.wr   <= bus.memwrite;
            req.idx  <= idx_c;
            req.data <= bus.writedata;
            if (misaligned_c) begin
              state      <= DONE;
              misalign_q <= 1'b1;
            end else begin
              cnt   <= CNT_W'(LATENCY - 1);
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          if (cnt == '0) begin
            if (req.wr) begin
              mem[req.idx] <= req.data;
            end else begin
              rdata     <= mem[req.idx];
              rdvalid_q <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          // One-cycle response window; a held request is not re-issued here.
          rdvalid_q  <= 1'b0;
          misalign_q <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (LATENCY=2, DEPTH=64): directed table,
// hand-written reset/abort sequences and randomized ops against a word-array model.
module tb_dmem_ctrl;

  localparam int unsigned L = 2;
  localparam int unsigned D = 64;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dmem_if #(.n(32)) bus ();

  dmem_ctrl #(.n(32), .DEPTH(D), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          scr;
    int          e_stall;
    int          e_rdv;
    int          e_mis;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] model [D];
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one request, optionally scrambling the bus after capture, and check the response.
  task automatic op(input string nm, input vec_t v);
    int          n_stall;
    int          n_rdv;
    int          n_mis;
    int          done_edge;
    logic [31:0] rd_at_valid;
    n_stall = 0;
    n_rdv = 0;
    n_mis = 0;
    rd_at_valid = 32'hx;
    done_edge = (v.e_stall > 0) ? v.e_stall - 1 : 0;
    bus.memread = v.rd;
    bus.memwrite = v.wr;
    bus.addr = v.a;
    bus.writedata = v.d;
    for (int c = 0; c < int'(L) + 4; c++) begin
      @(negedge clk);
      if (bus.stall) n_stall++;
      if (bus.misalign) n_mis++;
      if (bus.rdvalid) begin
        n_rdv++;
        rd_at_valid = bus.readdata;
      end
      @(posedge clk);
      #1;
      if (c >= done_edge) begin
        bus.memread = 1'b0;
        bus.memwrite = 1'b0;
      end else if (v.scr) begin
        bus.memread = 1'($urandom_range(1));
        bus.memwrite = 1'($urandom_range(1));
        bus.addr = $urandom;
        bus.writedata = $urandom;
      end
    end
    chk({nm, " stall_cycles"}, 32'(n_stall), 32'(v.e_stall));
    chk({nm, " rdvalid_cycles"}, 32'(n_rdv), 32'(v.e_rdv));
    chk({nm, " misalign_cycles"}, 32'(n_mis), 32'(v.e_mis));
    if (v.e_rdv > 0) chk({nm, " readdata_in_done"}, rd_at_valid, v.e_rd);
    chk({nm, " readdata_hold"}, bus.readdata, v.e_rd);
  endtask

  function automatic bit is_mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0 && (a[1:0] != 2'b00);
`endif
  endfunction

  // Reference behaviour from the word-level rules: index = (addr/4) mod DEPTH.
  function automatic vec_t model_op(input logic rd, input logic wr,
                                    input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    int   idx;
    v.rd = rd;
    v.wr = wr;
    v.a = a;
    v.d = d;
    v.scr = 1'b1;
    v.e_stall = 0;
    v.e_rdv = 0;
    v.e_mis = 0;
    idx = int'((a / 4) % D);
    if (rd || wr) begin
      if (is_mis(a)) begin
        v.e_stall = 1;
        v.e_mis = 1;
      end else begin
        v.e_stall = int'(L) + 1;
        if (wr) begin
          model[idx] = d;
        end else begin
          last_rd = model[idx];
          v.e_rdv = 1;
        end
      end
    end
    v.e_rd = last_rd;
    return v;
  endfunction

  initial begin
    total = 0;
    bad = 0;

    // Directed table: write/read-back, unwritten word, wrap, write priority, capture, offset.
    tbl[0] = '{1'b0, 1'b1, 32'h8,   32'h0000000F, 1'b0, 3, 0, 0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 3, 1, 0, 32'h0000000F};
    tbl[2] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 3, 1, 0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 3, 0, 0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 3, 1, 0, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 1'b1, 32'h4,   32'h0000000A, 1'b0, 3, 0, 0, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b0, 32'h4,   32'h0,        1'b0, 3, 1, 0, 32'h0000000A};
    tbl[7] = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b1, 3, 1, 0, 32'h0000000F};
`ifdef DMEM_ALIGN_CHECK_EN
    tbl[8] = '{1'b0, 1'b1, 32'h6,   32'h00000055, 1'b0, 1, 0, 1, 32'h0000000F};
    tbl[9] = '{1'b1, 1'b0, 32'h6,   32'h0,        1'b0, 1, 0, 1, 32'h0000000F};
`else
    tbl[8] = '{1'b0, 1'b1, 32'h6,   32'h00000055, 1'b0, 3, 0, 0, 32'h0000000F};
    tbl[9] = '{1'b1, 1'b0, 32'h6,   32'h0,        1'b0, 3, 1, 0, 32'h00000055};
`endif

    // Reset state, with requests asserted to show stall is held low.
    reset = 1'b1;
    bus.memread = 1'b1;
    bus.memwrite = 1'b1;
    bus.addr = 32'h8;
    bus.writedata = 32'h1;
    #3;
    chk("reset stall", 32'(bus.stall), 32'h0);
    chk("reset rdvalid", 32'(bus.rdvalid), 32'h0);
    chk("reset misalign", 32'(bus.misalign), 32'h0);
    chk("reset readdata", bus.readdata, 32'h0);
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) op($sformatf("vec%0d", i), tbl[i]);

    // Write aborted by reset while BUSY: stall drops with reset, memory stays zero.
    bus.memwrite = 1'b1;
    bus.addr = 32'h20;
    bus.writedata = 32'h12345678;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    chk("abort stall_busy", 32'(bus.stall), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort stall_reset", 32'(bus.stall), 32'h0);
    chk("abort readdata", bus.readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < int'(D); i++) model[i] = 32'h0;
    last_rd = 32'h0;
    op("abort readback", model_op(1'b1, 1'b0, 32'h20, 32'h0));
    op("reset cleared", model_op(1'b1, 1'b0, 32'h8, 32'h0));

    // Randomized ops against the model; addresses span wrap and sub-word offsets.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic        rd;
      logic        wr;
      a = $urandom_range(32'h3FF);
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      rd = 1'($urandom_range(1));
      wr = 1'($urandom_range(1));
      op($sformatf("rnd%0d", i), model_op(rd, wr, a, $urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter n, default 32, data and address width.
REQ-002 Parameter DEPTH, default 64, number of 32-bit words; power of two, at least 2.
REQ-003 Parameter LATENCY, default 2, access latency in cycles; at least 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 memwrite  input  1  write request from the controller.
REQ-007 memread  input  1  read request, driven from the load decode (memtoreg).
REQ-008 addr  input  n  byte address, driven from the datapath aluout.
REQ-009 writedata  input  n  store data from the datapath.
REQ-010 readdata  output  n  load result returned to the datapath.
REQ-011 rdvalid  output  1  readdata is updated and valid this cycle.
REQ-012 stall  output  1  freezes the datapath PC and register write while high.
REQ-013 misalign  output  1  misaligned-access flag (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE with memread or memwrite high, the SHALL-level action at the next edge: capture addr, writedata and op; load the counter with LATENCY-1; go to BUSY.
REQ-016 In BUSY, the counter SHALL decrement each cycle; at count 0 the next edge performs the access and enters DONE.
REQ-017 In DONE, the FSM SHALL return to IDLE unconditionally; a request held high in DONE is not re-issued.
REQ-018 stall SHALL equal (IDLE and (memread or memwrite)) or BUSY; it is combinational and high for exactly LATENCY+1 cycles per request.
REQ-019 A read SHALL load readdata with mem[index] at the BUSY-to-DONE edge; rdvalid is high only in DONE.
REQ-020 A write SHALL store the captured writedata at the BUSY-to-DONE edge; rdvalid stays 0 and readdata holds its value.
REQ-021 When memread and memwrite are both high, the write SHALL take priority and no read SHALL be performed.
REQ-022 index SHALL be addr[log2(DEPTH)+1:2]; higher address bits are ignored, so accesses wrap modulo DEPTH words.
REQ-023 Changes on addr, writedata, memread or memwrite during BUSY or DONE SHALL have no effect.
REQ-024 readdata SHALL hold its last value between reads.

Reset
REQ-025 Asserting reset SHALL immediately force: state=IDLE, counter=0, readdata=0, rdvalid=0, misalign=0, stall=0, and all memory words=0.
REQ-026 Reset asserted mid-BUSY SHALL abort the access: no memory write and no readdata update.
REQ-027 stall SHALL be held 0 while reset is high, regardless of memread or memwrite.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: a request with addr[1:0] not equal to 0 SHALL go from IDLE directly to DONE, skipping BUSY.
  - stall is high for 1 cycle only.
  - No memory access; readdata unchanged; rdvalid=0.
  - misalign=1 for that DONE cycle only.
REQ-029 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored and misalign SHALL be tied to 0.

Verification (LATENCY=2, DEPTH=64)
REQ-030 Write and read-back: reset, write 0x0000000F to addr 0x8 -> stall high 3 cycles, rdvalid=0; then read 0x8 -> rdvalid=1 with readdata=0x0000000F in DONE.
REQ-031 Unwritten location: read addr 0x10 after reset -> readdata=0x00000000, rdvalid=1 one cycle.
REQ-032 Address wrap: write 0xDEADBEEF to addr 0x100, then read addr 0x0 -> readdata=0xDEADBEEF.
REQ-033 Write priority: memread=memwrite=1, addr 0x4, data 0x0000000A -> rdvalid=0, readdata unchanged; a later read of 0x4 returns 0x0000000A.
REQ-034 Capture and abort:
  - Read 0x8 with addr changed to 0xC during BUSY -> 0x8 data returned.
  - Write aborted by reset in BUSY -> location reads 0 and stall drops with reset.
REQ-035 Misalignment: addr 0x6 with the macro -> stall 1 cycle, misalign=1; without the macro -> behaves as addr 0x4.
